shim_integ_threshold: RTL and testbench
=======================================

// Module: shim_integ_threshold
// PURPOSE
//  SPI-domain over-current guard fed by the spi_clk-synchronised config outputs (integ_en/thresh_avg/window).
//  Sums |DAC sample| per channel over each integ_window-cycle window; compares each sum with thresh_avg*count.
//  Raises a sticky per-channel fault that the shim top uses to force spi_en low and hold buffers blocked.
// PARAMETERS
//  CHANNELS  8   number of DAC channels (>=1)
//  CH_W      3   channel index width, $clog2(CHANNELS) (>=1)
// PORTS
//  spi_clk           in   1         SPI domain clock
//  spi_resetn        in   1         async active-low reset
//  integ_en          in   1         integrator enable (synchronised level)
//  integ_thresh_avg  in   15        per-sample average |value| threshold
//  integ_window      in   32        window length in spi_clk cycles
//  sample_valid      in   1         DAC sample strobe, one channel per cycle
//  sample_ch         in   CH_W      channel of sample
//  sample_val        in   16        signed two's-complement DAC word
//  over_thresh       out  1         OR of over_thresh_ch
//  over_thresh_ch    out  CHANNELS  sticky per-channel fault
//  integ_active      out  1         high in RUN/EVAL
// BEHAVIOUR
//  Reset (async, spi_resetn=0): all outputs 0, state IDLE; accumulators, counts, snapshots, win_cnt = 0.
//  FSM IDLE->RUN when integ_en=1; RUN->EVAL at window end; EVAL->RUN after CHANNELS cycles.
//  integ_en=0 in any state -> IDLE next edge: clears accumulators and over_thresh_ch (fault release is SW's job).
//  On RUN entry: latch thr=integ_thresh_avg, win=max(integ_window, CHANNELS+2); win_cnt=0.
//  Window end = RUN cycle with win_cnt==win-1.
//  Config is re-latched at each window start; mid-window config changes have no effect.
//  Accumulate (RUN and EVAL): on sample_valid with sample_ch<CHANNELS:
//    acc[ch] += |sample_val| (17-bit abs, -32768 -> 32768); cnt[ch] += 1; visible next cycle.
//  sample_ch>=CHANNELS: sample ignored.
//  acc is 49 bits, cnt 33 bits; both saturate at all-ones, never wrap.
//  Window-end edge: snap_acc/snap_cnt <= acc/cnt; acc/cnt cleared.
//    A sample valid in that same cycle is the first term of the new window (acc=|s|, cnt=1).
//  Window counting continues during EVAL (win_cnt restarts at the window-end edge, uses new latched win).
//    win>=CHANNELS+2 guarantees EVAL finishes before the next window end.
//  EVAL: cycle k (0..CHANNELS-1) compares snap_acc[k] > thr*snap_cnt[k] (48-bit product, unsigned, strict >).
//    A true result sets over_thresh_ch[k] at end of that cycle: flag k visible k+2 cycles after window-end edge.
//  cnt=0 -> never faults. Flags are sticky: only integ_en=0 or reset clear them.
//  over_thresh is registered in the same cycle as the bit that sets it.
//  integ_active = (state != IDLE).
// CONFIGURATION
//  SHIM_INTEG_STATUS_EN defined: adds outputs window_done (1-cycle pulse on each window-end edge)
//    and window_count[15:0] (windows completed since RUN entry, wraps at 0xFFFF, 0 in IDLE/reset).
//  SHIM_INTEG_STATUS_EN undefined: those ports and their counter are absent; all other behaviour identical.
// STRUCTURE
//  Package shim_integ_pkg: state enum {IDLE,RUN,EVAL}; ACC_W=49, CNT_W=33, SAMPLE_W=16,
//    THR_W=15, WIN_W=32 constants; min-window function.
//  One sub-module shim_integ_cmp: combinational abs + saturating add helpers and the shared
//    thr*cnt multiply/compare used once per EVAL cycle.
// TESTING  (CHANNELS=4, win=100, thr=0x1000)
//  ch0 gets 0x0FFF every cycle for 3 windows -> over_thresh stays 0.
//  ch0 gets 0x1001 every cycle -> over_thresh_ch=4'b0001 exactly 2 cycles after the first window-end edge.
//  ch2 gets -0x1001 (0xEFFF) alternating with 0x0000 -> no fault (avg < thr);
//    constant 0xEFFF -> bit2 set (abs path).
//  Fault set, then integ_en=0 one cycle -> flags 0, IDLE.
//  Re-enable with integ_window=2 -> window length 6 cycles (clamp).
//  No samples for a window -> no fault. Sample coinciding with the window-end edge counted in the next window only.
//  spi_resetn pulsed mid-EVAL -> all outputs 0 immediately (async);
//    with integ_en still 1, RUN resumes on the first edge after release.

Source files
------------

// File: rtl/shim_integ_pkg.sv
// Shared types and constants for the SPI-domain over-current integrator.
// Contents: FSM state enum, datapath widths, window-length clamp helper.
package shim_integ_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned ABS_W     = 17;
  localparam int unsigned THR_W     = 15;
  localparam int unsigned WIN_W     = 32;
  localparam int unsigned ACC_W     = 49;
  localparam int unsigned ACC_EXT_W = ACC_W + 1;
  localparam int unsigned CNT_W     = 33;
  localparam int unsigned CNT_EXT_W = CNT_W + 1;
  localparam int unsigned PROD_W    = 48;
  localparam int unsigned STAT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EVAL = 2'd2
  } state_e;

  // A window must outlast the CHANNELS-cycle evaluation plus its result pipeline.
  function automatic logic [WIN_W-1:0] min_window(input logic [WIN_W-1:0] win,
                                                  input int unsigned      channels);
    logic [WIN_W-1:0] floor_w;
    floor_w = WIN_W'(channels + 32'd2);
    return (win < floor_w) ? floor_w : win;
  endfunction

endpackage

// File: rtl/shim_integ_cmp.sv
// Combinational datapath for the integrator: |sample| with saturating
// accumulate, saturating sample count, and the single shared thr*cnt
// multiply/compare used once per evaluation cycle.
// Ports:
//   i_sample_val  signed DAC word
//   i_acc/i_cnt   current accumulator/count of the sampled channel
//   i_thr         threshold latched for the evaluated window
//   i_snap_acc/i_snap_cnt  snapshot of the channel being evaluated
//   o_acc_sum_c/o_cnt_sum_c  saturated updated accumulator/count
//   o_over_c      snapshot average strictly above threshold
module shim_integ_cmp
  import shim_integ_pkg::*;
(
  input  logic [SAMPLE_W-1:0] i_sample_val,
  input  logic [ACC_W-1:0]    i_acc,
  input  logic [CNT_W-1:0]    i_cnt,
  input  logic [THR_W-1:0]    i_thr,
  input  logic [ACC_W-1:0]    i_snap_acc,
  input  logic [CNT_W-1:0]    i_snap_cnt,
  output logic [ACC_W-1:0]    o_acc_sum_c,
  output logic [CNT_W-1:0]    o_cnt_sum_c,
  output logic                o_over_c
);

  logic [ABS_W-1:0]     w_ext;
  logic [ABS_W-1:0]     w_abs;
  logic [ACC_EXT_W-1:0] w_acc_wide;
  logic [CNT_EXT_W-1:0] w_cnt_wide;
  logic [PROD_W-1:0]    w_prod;

  always_comb begin
    // 17-bit magnitude so -32768 maps to +32768 without overflow.
    w_ext = {i_sample_val[SAMPLE_W-1], i_sample_val};
    w_abs = i_sample_val[SAMPLE_W-1] ? ((~w_ext) + ABS_W'(1)) : w_ext;

    // Carry out of the widened sum means saturate rather than wrap.
    w_acc_wide  = {1'b0, i_acc} + ACC_EXT_W'(w_abs);
    o_acc_sum_c = w_acc_wide[ACC_W] ? {ACC_W{1'b1}} : w_acc_wide[ACC_W-1:0];

    w_cnt_wide  = {1'b0, i_cnt} + CNT_EXT_W'(1);
    o_cnt_sum_c = w_cnt_wide[CNT_W] ? {CNT_W{1'b1}} : w_cnt_wide[CNT_W-1:0];

    // 15b x 33b fits in 48 bits; an empty window never faults.
    w_prod   = PROD_W'(i_thr) * PROD_W'(i_snap_cnt);
    o_over_c = (i_snap_cnt != '0) && (i_snap_acc > ACC_W'(w_prod));
  end

endmodule

// File: rtl/shim_integ_threshold.sv
// SPI-domain over-current guard. Integrates |DAC sample| per channel over
// a programmable window, then checks each channel's sum against
// thr * sample_count and raises a sticky per-channel fault.
// Ports:
//   spi_clk, spi_resetn   clock, async active-low reset
//   integ_en              enable level; low clears state and faults
//   integ_thresh_avg      per-sample average |value| threshold
//   integ_window          window length in cycles (clamped to CHANNELS+2)
//   sample_valid/sample_ch/sample_val  one DAC sample per cycle
//   over_thresh           OR of over_thresh_ch
//   over_thresh_ch        sticky per-channel fault
//   integ_active          high while not IDLE
// Optional (SHIM_INTEG_STATUS_EN): window_done pulse, window_count.
module shim_integ_threshold
  import shim_integ_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CH_W     = 3
) (
  input  logic                spi_clk,
  input  logic                spi_resetn,
  input  logic                integ_en,
  input  logic [THR_W-1:0]    integ_thresh_avg,
  input  logic [WIN_W-1:0]    integ_window,
  input  logic                sample_valid,
  input  logic [CH_W-1:0]     sample_ch,
  input  logic [SAMPLE_W-1:0] sample_val,
`ifdef SHIM_INTEG_STATUS_EN
  output logic                window_done,
  output logic [STAT_W-1:0]   window_count,
`endif
  output logic                over_thresh,
  output logic [CHANNELS-1:0] over_thresh_ch,
  output logic                integ_active
);

  state_e              r_state;
  logic [THR_W-1:0]    r_thr;
  logic [THR_W-1:0]    r_snap_thr;
  logic [WIN_W-1:0]    r_win;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [CH_W-1:0]     r_eval_idx;
  logic                r_hit;
  logic [CH_W-1:0]     r_hit_idx;
  logic [CHANNELS-1:0] r_flags;
  logic                r_over;
  logic                r_active;
  logic [ACC_W-1:0]    r_acc      [CHANNELS];
  logic [CNT_W-1:0]    r_cnt      [CHANNELS];
  logic [ACC_W-1:0]    r_snap_acc [CHANNELS];
  logic [CNT_W-1:0]    r_snap_cnt [CHANNELS];
`ifdef SHIM_INTEG_STATUS_EN
  logic                r_win_done;
  logic [STAT_W-1:0]   r_win_num;
`endif

  logic                w_win_end;
  logic                w_smp_ok;
  logic [ACC_W-1:0]    w_acc_sel;
  logic [CNT_W-1:0]    w_cnt_sel;
  logic [ACC_W-1:0]    w_snap_acc_sel;
  logic [CNT_W-1:0]    w_snap_cnt_sel;
  logic [ACC_W-1:0]    w_acc_sum;
  logic [CNT_W-1:0]    w_cnt_sum;
  logic                w_over;
  logic [CHANNELS-1:0] w_flags_nxt;

  // Window-end detect, operand muxing for the shared datapath, flag merge.
  always_comb begin
    w_win_end      = (r_state == RUN) && (r_win_cnt == (r_win - WIN_W'(1)));
    w_smp_ok       = sample_valid && (32'(sample_ch) < CHANNELS);
    w_acc_sel      = '0;
    w_cnt_sel      = '0;
    w_snap_acc_sel = '0;
    w_snap_cnt_sel = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (sample_ch == CH_W'(i)) begin
        w_acc_sel = r_acc[i];
        w_cnt_sel = r_cnt[i];
      end
      if (r_eval_idx == CH_W'(i)) begin
        w_snap_acc_sel = r_snap_acc[i];
        w_snap_cnt_sel = r_snap_cnt[i];
      end
    end
    // A sample on the window-end cycle opens the next window from zero.
    if (w_win_end) begin
      w_acc_sel = '0;
      w_cnt_sel = '0;
    end
    w_flags_nxt = r_flags | (r_hit ? (CHANNELS'(1) << r_hit_idx) : '0);
  end

  shim_integ_cmp u_cmp (
    .i_sample_val (sample_val),
    .i_acc        (w_acc_sel),
    .i_cnt        (w_cnt_sel),
    .i_thr        (r_snap_thr),
    .i_snap_acc   (w_snap_acc_sel),
    .i_snap_cnt   (w_snap_cnt_sel),
    .o_acc_sum_c  (w_acc_sum),
    .o_cnt_sum_c  (w_cnt_sum),
    .o_over_c     (w_over)
  );

  // FSM, accumulators, evaluation pipeline and sticky flags.
  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      r_state    <= IDLE;
      r_thr      <= '0;
      r_snap_thr <= '0;
      r_win      <= '0;
      r_win_cnt  <= '0;
      r_eval_idx <= '0;
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
      r_flags    <= '0;
      r_over     <= 1'b0;
      r_active   <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_acc[i]      <= '0;
        r_cnt[i]      <= '0;
        r_snap_acc[i] <= '0;
        r_snap_cnt[i] <= '0;
      end
`ifdef SHIM_INTEG_STATUS_EN
      r_win_done <= 1'b0;
      r_win_num  <= '0;
`endif
    end else if (!integ_en) begin
      // Disable releases faults and restarts integration from scratch.
      r_state    <= IDLE;
      r_win_cnt  <= '0;
      r_eval_idx <= '0;
      r_hit      <= 1'b0;
      r_flags    <= '0;
      r_over     <= 1'b0;
      r_active   <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
`ifdef SHIM_INTEG_STATUS_EN
      r_win_done <= 1'b0;
      r_win_num  <= '0;
`endif
    end else begin
      // Result of EVAL cycle k lands in the flag register one cycle later.
      r_hit     <= (r_state == EVAL) && w_over;
      r_hit_idx <= r_eval_idx;
      r_flags   <= w_flags_nxt;
      r_over    <= |w_flags_nxt;
`ifdef SHIM_INTEG_STATUS_EN
      r_win_done <= w_win_end;
      if (w_win_end) begin
        r_win_num <= r_win_num + STAT_W'(1);
      end
`endif

      if (r_state != IDLE) begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
          if (w_win_end) begin
            r_snap_acc[i] <= r_acc[i];
            r_snap_cnt[i] <= r_cnt[i];
            r_acc[i]      <= '0;
            r_cnt[i]      <= '0;
          end
          if (w_smp_ok && (sample_ch == CH_W'(i))) begin
            r_acc[i] <= w_acc_sum;
            r_cnt[i] <= w_cnt_sum;
          end
        end
      end

      case (r_state)
        IDLE: begin
          r_state   <= RUN;
          r_active  <= 1'b1;
          r_thr     <= integ_thresh_avg;
          r_win     <= min_window(integ_window, CHANNELS);
          r_win_cnt <= '0;
        end
        RUN: begin
          if (w_win_end) begin
            r_state    <= EVAL;
            r_eval_idx <= '0;
            r_snap_thr <= r_thr;
            r_thr      <= integ_thresh_avg;
            r_win      <= min_window(integ_window, CHANNELS);
            r_win_cnt  <= '0;
          end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
          end
        end
        EVAL: begin
          r_win_cnt  <= r_win_cnt + WIN_W'(1);
          r_eval_idx <= r_eval_idx + CH_W'(1);
          if (r_eval_idx == CH_W'(CHANNELS - 1)) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign over_thresh    = r_over;
  assign over_thresh_ch = r_flags;
  assign integ_active   = r_active;
`ifdef SHIM_INTEG_STATUS_EN
  assign window_done    = r_win_done;
  assign window_count   = r_win_num;
`endif

endmodule

// File: tb/tb_shim_integ_threshold.sv
// Self-checking bench for shim_integ_threshold (CHANNELS=4).
// A reference model computes per-window sums; at each window end it queues
// the expected fault bits with their due edge, and they are popped into the
// expected flag vector when that edge arrives.
`timescale 1ns/1ps
module tb_shim_integ_threshold;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  logic            spi_clk = 1'b0;
  logic            spi_resetn = 1'b0;
  logic            integ_en = 1'b0;
  logic [14:0]     integ_thresh_avg = '0;
  logic [31:0]     integ_window = '0;
  logic            sample_valid = 1'b0;
  logic [CHW-1:0]  sample_ch = '0;
  logic [15:0]     sample_val = '0;
  logic            over_thresh;
  logic [NCH-1:0]  over_thresh_ch;
  logic            integ_active;
  logic [5:0]      obs;

  assign obs = {over_thresh, over_thresh_ch, integ_active};

  shim_integ_threshold #(.CHANNELS(NCH), .CH_W(CHW)) dut (
    .spi_clk          (spi_clk),
    .spi_resetn       (spi_resetn),
    .integ_en         (integ_en),
    .integ_thresh_avg (integ_thresh_avg),
    .integ_window     (integ_window),
    .sample_valid     (sample_valid),
    .sample_ch        (sample_ch),
    .sample_val       (sample_val),
    .over_thresh      (over_thresh),
    .over_thresh_ch   (over_thresh_ch),
    .integ_active     (integ_active)
  );

  always #5 spi_clk = ~spi_clk;

  typedef struct {
    int due;
    int idx;
  } pend_t;

  pend_t          pend_q[$];
  int             n_checks = 0;
  int             n_fail = 0;
  int             edge_n = 0;
  logic           m_on = 1'b0;
  logic [NCH-1:0] m_flags = '0;
  longint         m_pos = 0;
  longint         m_win = 0;
  longint         m_thr = 0;
  longint         m_acc [NCH];
  longint         m_cnt [NCH];

  function automatic longint abs16(input logic [15:0] v);
    return v[15] ? (longint'(65536) - longint'(v)) : longint'(v);
  endfunction

  function automatic longint win_of(input logic [31:0] w);
    return (longint'(w) < longint'(NCH + 2)) ? longint'(NCH + 2) : longint'(w);
  endfunction

  function automatic logic [5:0] exp_vec();
    return {|m_flags, m_flags, m_on};
  endfunction

  task automatic model_clear();
    m_on    = 1'b0;
    m_flags = '0;
    m_pos   = 0;
    pend_q.delete();
    for (int k = 0; k < int'(NCH); k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
    end
  endtask

  // Drive one cycle of sample input, advance the model across the edge,
  // and return at the following falling edge.
  task automatic step(input logic v, input int ch, input logic [15:0] val);
    longint a;
    sample_valid = v;
    sample_ch    = CHW'(ch);
    sample_val   = val;
    @(posedge spi_clk);
    edge_n++;
    a = abs16(val);
    if (!integ_en) begin
      model_clear();
    end else if (!m_on) begin
      m_on  = 1'b1;
      m_pos = 0;
      m_win = win_of(integ_window);
      m_thr = longint'(integ_thresh_avg);
    end else begin
      if (m_pos == m_win - 1) begin
        for (int k = 0; k < int'(NCH); k++) begin
          if (m_cnt[k] != 0 && m_acc[k] > m_thr * m_cnt[k])
            pend_q.push_back('{due: edge_n + k + 2, idx: k});
          m_acc[k] = 0;
          m_cnt[k] = 0;
        end
        m_pos = 0;
        m_win = win_of(integ_window);
        m_thr = longint'(integ_thresh_avg);
      end else begin
        m_pos++;
      end
      if (v && ch < int'(NCH)) begin
        m_acc[ch] += a;
        m_cnt[ch]++;
      end
    end
    for (int i = pend_q.size() - 1; i >= 0; i--) begin
      if (pend_q[i].due == edge_n) begin
        m_flags[pend_q[i].idx] = 1'b1;
        pend_q.delete(i);
      end
    end
    @(negedge spi_clk);
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 6'b0);
    end
    @(negedge spi_clk);
    spi_resetn = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, 16'h7FFF);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_idle edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
    end
  endtask

  task automatic test_disable();
    integ_en = 1'b0;
    step(1'b0, 0, 16'h0000);
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL disable_clear got=%b exp=%b", obs, 6'b0);
    end
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL disable_model got=%b exp=%b", obs, exp_vec());
    end
  endtask

  task automatic test_below();
    integ_thresh_avg = 15'h1000;
    integ_window     = 32'd100;
    integ_en         = 1'b1;
    for (int i = 0; i < 320; i++) begin
      step(1'b1, 0, 16'h0FFF);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL below edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
    end
    n_checks++;
    if (over_thresh !== 1'b0) begin
      n_fail++;
      $display("FAIL below_final got=%b exp=0", over_thresh);
    end
  endtask

  task automatic test_over();
    logic [NCH-1:0] want;
    integ_en = 1'b1;
    for (int i = 0; i < 110; i++) begin
      step(1'b1, 0, 16'h1001);
      want = (i >= 102) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL over edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
      n_checks++;
      if (over_thresh_ch !== want) begin
        n_fail++;
        $display("FAIL over_timing step=%0d got=%b exp=%b", i, over_thresh_ch, want);
      end
    end
  endtask

  task automatic test_abs();
    integ_en = 1'b1;
    for (int i = 0; i < 210; i++) begin
      step(1'b1, 2, (i % 2 == 1) ? 16'hEFFF : 16'h0000);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL abs_alt edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
    end
    n_checks++;
    if (over_thresh_ch !== 4'b0000) begin
      n_fail++;
      $display("FAIL abs_alt_final got=%b exp=%b", over_thresh_ch, 4'b0000);
    end
    for (int i = 0; i < 210; i++) begin
      step(1'b1, 2, 16'hEFFF);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL abs_const edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
    end
    n_checks++;
    if ({over_thresh, over_thresh_ch} !== 5'b1_0100) begin
      n_fail++;
      $display("FAIL abs_const_final got=%b exp=%b", {over_thresh, over_thresh_ch}, 5'b1_0100);
    end
  endtask

  task automatic test_clamp();
    logic [NCH-1:0] want;
    integ_window = 32'd2;
    integ_en     = 1'b1;
    step(1'b0, 0, 16'h0000);
    for (int i = 1; i <= 14; i++) begin
      step(1'b1, 1, 16'h2000);
      want = (i >= 9) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL clamp edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
      n_checks++;
      if (over_thresh_ch !== want) begin
        n_fail++;
        $display("FAIL clamp_timing step=%0d got=%b exp=%b", i, over_thresh_ch, want);
      end
    end
  endtask

  task automatic test_edge_sample();
    logic [NCH-1:0] want;
    integ_window = 32'd2;
    integ_en     = 1'b1;
    step(1'b0, 0, 16'h0000);
    for (int i = 1; i <= 20; i++) begin
      step(i == 6, 3, 16'h7FFF);
      want = (i >= 17) ? 4'b1000 : 4'b0000;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL edge_sample edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
      n_checks++;
      if (over_thresh_ch !== want) begin
        n_fail++;
        $display("FAIL edge_sample_timing step=%0d got=%b exp=%b", i, over_thresh_ch, want);
      end
    end
  endtask

  task automatic test_reset_mid_eval();
    integ_window = 32'd2;
    integ_en     = 1'b1;
    step(1'b0, 0, 16'h0000);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 0, 16'h1001);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL pre_reset edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
    end
    n_checks++;
    if (obs !== 6'b1_0001_1) begin
      n_fail++;
      $display("FAIL pre_reset_flag got=%b exp=%b", obs, 6'b1_0001_1);
    end
    #2;
    spi_resetn = 1'b0;
    #1;
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=%b", obs, 6'b0);
    end
    model_clear();
    @(negedge spi_clk);
    spi_resetn = 1'b1;
    step(1'b1, 0, 16'h1001);
    n_checks++;
    if (integ_active !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_active got=%b exp=1", integ_active);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 0, 16'h1001);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL resume edge=%0d got=%b exp=%b", edge_n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_below();
    test_disable();
    test_over();
    test_disable();
    test_abs();
    test_disable();
    test_clamp();
    test_disable();
    test_edge_sample();
    test_disable();
    test_reset_mid_eval();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
